qpmm_arbiter: RTL
=================

# qpmm_arbiter

Round-robin scheduler that shares one pipelined BN254 QPMM Montgomery multiplier among several requesters. Accepts operand pairs over valid/ready handshakes and issues at most one multiplication per cycle. Carries each operation's requester ID through a shadow tag pipeline matched to the multiplier latency, and routes each product back to its owner. Sits between the pairing-level sequencers (Fp2/Fp12 engines) and the single multiplier instance.

## Interface
- N_REQ, 4, number of requesters (2..8)
- LAT, 14, multiplier latency in cycles, from mm_valid_o to mm_valid_i
- MAX_OUT, 4, maximum in-flight operations per requester (1..15)
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- cfg_en  in  1  level; 1 = grant requests, 0 = stop granting and drain
- req_valid  in  N_REQ  per-requester operand valid
- req_ready  out  N_REQ  per-requester accept; combinational
- req_a  in  N_REQ×288  operand A per requester (qpmm_fpa_t)
- req_b  in  N_REQ×272  operand B per requester (qpmm_fpb_t)
- mm_valid_o / mm_a_o / mm_b_o  out  1/288/272  issue to the multiplier; registered
- mm_valid_i / mm_z_i  in  1/272  multiplier result
- res_valid  out  N_REQ  one-hot result strobe; registered; no backpressure
- res_z  out  272  result data (qpmm_fp_t), valid while any res_valid bit is set
- idle_o  out  1  1 when state is IDLE
- err_o  out  1  sticky; set when mm_valid_i disagrees with tag-pipe valid

## Operation
- States:
  - IDLE: on cfg_en=1, go to RUN next cycle.
  - RUN: grants enabled; on cfg_en=0, go to DRAIN.
  - DRAIN: no grants; when the tag pipe is empty and the result register is idle, go to IDLE. If cfg_en returns to 1 during DRAIN, go to RUN immediately.
- Eligibility: req_valid[i] & (out_cnt[i] < MAX_OUT) & state==RUN.
- Grant: first eligible index at or after rr_ptr, with wrap-around. At most one grant per cycle. req_ready is asserted only for the grantee. A handshake is req_valid & req_ready.
- rr_ptr: after a handshake with grantee g, rr_ptr = (g+1) mod N_REQ. Unchanged when there is no handshake.
- Issue register: captures the grantee's a/b and sets mm_valid_o for one cycle. Otherwise mm_valid_o=0 and the data holds its last value.
- Tag pipe: LAT stages of {valid, id[$clog2(N_REQ)-1:0]}, loaded in step with mm_valid_o.
- Result: when the stage-LAT tag is valid, res_valid[id] and res_z are set from mm_z_i on the next cycle. If mm_valid_i ≠ tag valid, set err_o and drop that result.
- out_cnt[i]: increments on a handshake, decrements on a res_valid[i] strobe. If both occur in the same cycle, the count is unchanged. It never exceeds MAX_OUT.
- Reset values:
  - all outputs 0 except idle_o=1
  - state IDLE, rr_ptr 0, all out_cnt 0, tag pipe cleared
  - Reset mid-operation discards all in-flight operations. Late mm_valid_i pulses after release set err_o.

## Timing
- Handshake in cycle t gives mm_valid_o at t+1, mm_valid_i expected at t+1+LAT, and res_valid at t+2+LAT (16 with defaults).
- Sustained throughput is 1 op/cycle. A requester alone with MAX_OUT ≥ LAT+2 sustains 1 op/cycle.
- After a result strobe, out_cnt frees the slot in time for a grant in the same strobe cycle. req_ready may rise in the cycle res_valid asserts.
- idle_o rises the cycle after the DRAIN→IDLE transition.

## Configuration
- QPMM_ARB_STATS_EN defined: adds a 32-bit saturating grant counter per requester, cleared by reset. Adds outputs stat_grants (N_REQ×32) and stat_busy (32), the count of cycles with mm_valid_o=1.
- QPMM_ARB_STATS_EN undefined: the counters and both ports are absent. All other behaviour is identical.

## Structure
- PARAMS_BN254_d0 package provides qpmm_fpa_t, qpmm_fpb_t and qpmm_fp_t. Add arb_tag_t and arb_state_t (IDLE/RUN/DRAIN) to that package.
- One sub-module, qpmm_rr_grant: a combinational round-robin priority encoder taking eligibility and rr_ptr, producing a one-hot grant and the grant index.
- The tag pipe and counters stay in the top level.

## Test plan
- Single op: cfg_en=1, req0 a=2, b=3 at t. Expect mm_valid_o at t+1 with mm_a_o=2, and res_valid=4'b0001 at t+16 carrying the model mm_z_i.
- Fairness: all four req_valid held high for 8 cycles from rr_ptr=0. Expect grants 0,1,2,3,0,1,2,3 and each out_cnt=2.
- Credit limit: MAX_OUT=4, req2 alone held for 20 cycles. Expect 4 grants at t..t+3, req_ready[2]=0 until t+16, then one grant per cycle.
- Drain: cfg_en→0 with 3 ops in flight. Expect state DRAIN with no further grants, 3 res_valid strobes, then idle_o=1 one cycle after the last strobe.
- Reset mid-flight: rst_n low with 5 ops in flight. Expect all outputs 0 and idle_o=1 at once, and no res_valid after release.
- Stats (macro on): rerun fairness. Expect stat_grants = 2 per requester and stat_busy = 8. With the macro off, verify the ports are absent and results match.

Source files
------------

// File: rtl/PARAMS_BN254_d0.sv
// BN254 field operand types shared by the QPMM arbiter, plus arbiter tag/state types.
// The optional statistics block of qpmm_arbiter is enabled by QPMM_ARB_STATS_EN.
package PARAMS_BN254_d0;

    localparam int unsigned FpaW   = 288;
    localparam int unsigned FpbW   = 272;
    localparam int unsigned FpW    = 272;
    localparam int unsigned ArbIdW = 3;  // wide enough for up to 8 requesters
    localparam int unsigned CntW   = 4;  // in-flight counts up to 15

    typedef logic [FpaW-1:0] qpmm_fpa_t;
    typedef logic [FpbW-1:0] qpmm_fpb_t;
    typedef logic [FpW-1:0]  qpmm_fp_t;

    typedef struct packed {
        logic              valid;
        logic [ArbIdW-1:0] id;
    } arb_tag_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } arb_state_t;

    function automatic logic [ArbIdW-1:0] rr_next(input logic [ArbIdW-1:0] idx,
                                                  input int unsigned n);
        if (32'(idx) + 32'd1 >= n) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/qpmm_rr_grant.sv
// Combinational round-robin priority encoder: first eligible index at or after ptr_i, wrapping.
module qpmm_rr_grant
    import PARAMS_BN254_d0::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]  elig_i,
    input  logic [ArbIdW-1:0] ptr_i,
    output logic [N_REQ-1:0]  gnt_o,
    output logic [ArbIdW-1:0] idx_o,
    output logic              any_o
);

    always_comb begin
        int unsigned j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = 32'(ptr_i) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!any_o && elig_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = ArbIdW'(j);
            end
        end
    end

endmodule

// File: rtl/qpmm_arbiter.sv
// Round-robin scheduler sharing one pipelined QPMM multiplier; IDs ride a shadow tag pipe.
// Define QPMM_ARB_STATS_EN to add per-requester grant counters and a busy-cycle counter.
module qpmm_arbiter
    import PARAMS_BN254_d0::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned LAT     = 14,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_en,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*FpaW-1:0] req_a,
    input  logic [N_REQ*FpbW-1:0] req_b,
    output logic                  mm_valid_o,
    output logic [FpaW-1:0]       mm_a_o,
    output logic [FpbW-1:0]       mm_b_o,
    input  logic                  mm_valid_i,
    input  logic [FpW-1:0]        mm_z_i,
    output logic [N_REQ-1:0]      res_valid,
    output logic [FpW-1:0]        res_z,
    output logic                  idle_o,
    output logic                  err_o
`ifdef QPMM_ARB_STATS_EN
    ,
    output logic [N_REQ*32-1:0]   stat_grants,
    output logic [31:0]           stat_busy
`endif
);

    localparam logic [CntW-1:0] MaxOutC = CntW'(MAX_OUT);

    arb_state_t        state_q, state_d;
    logic [ArbIdW-1:0] ptr_q;
    logic [CntW-1:0]   cnt_q [N_REQ];
    arb_tag_t          tag_q [LAT];
    arb_tag_t          tag_last;
    logic [ArbIdW-1:0] iss_id_q;
    logic              mm_valid_q;
    qpmm_fpa_t         mm_a_q, a_sel;
    qpmm_fpb_t         mm_b_q, b_sel;
    logic [N_REQ-1:0]  res_valid_q, res_valid_d;
    qpmm_fp_t          res_z_q;
    logic              err_q, err_d;
    logic [N_REQ-1:0]  elig, gnt;
    logic [ArbIdW-1:0] gnt_idx;
    logic              gnt_any;
    logic              pipe_busy;

    // A slot freed by this cycle's result strobe is reusable in the same cycle.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid[i] & ((cnt_q[i] < MaxOutC) | res_valid_q[i]) &
                      (state_q == StRun);
        end
    end

    qpmm_rr_grant #(
        .N_REQ (N_REQ)
    ) u_rr_grant (
        .elig_i (elig),
        .ptr_i  (ptr_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx),
        .any_o  (gnt_any)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                a_sel = req_a[i*FpaW +: FpaW];
                b_sel = req_b[i*FpbW +: FpbW];
            end
        end
    end

    always_comb begin
        pipe_busy = mm_valid_q;
        for (int k = 0; k < LAT; k++) begin
            pipe_busy = pipe_busy | tag_q[k].valid;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cfg_en) state_d = StRun;
            StRun:   if (!cfg_en) state_d = StDrain;
            StDrain: begin
                if (cfg_en) begin
                    state_d = StRun;
                end else if (!pipe_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Results whose multiplier valid disagrees with the tag are dropped and flagged.
    always_comb begin
        tag_last    = tag_q[LAT-1];
        res_valid_d = '0;
        if (tag_last.valid && mm_valid_i) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (tag_last.id == ArbIdW'(i)) begin
                    res_valid_d[i] = 1'b1;
                end
            end
        end
        err_d = err_q | (mm_valid_i ^ tag_last.valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            mm_valid_q  <= 1'b0;
            mm_a_q      <= '0;
            mm_b_q      <= '0;
            iss_id_q    <= '0;
            res_valid_q <= '0;
            res_z_q     <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
            for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            mm_valid_q  <= gnt_any;
            if (|res_valid_d) res_z_q <= mm_z_i;
            if (gnt_any) begin
                mm_a_q   <= a_sel;
                mm_b_q   <= b_sel;
                iss_id_q <= gnt_idx;
                ptr_q    <= rr_next(gnt_idx, N_REQ);
            end
            tag_q[0] <= '{valid: mm_valid_q, id: iss_id_q};
            for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_q[i] + CntW'(gnt[i]) - CntW'(res_valid_q[i]);
            end
        end
    end

    assign req_ready  = gnt;
    assign mm_valid_o = mm_valid_q;
    assign mm_a_o     = mm_a_q;
    assign mm_b_o     = mm_b_q;
    assign res_valid  = res_valid_q;
    assign res_z      = res_z_q;
    assign idle_o     = (state_q == StIdle);
    assign err_o      = err_q;

`ifdef QPMM_ARB_STATS_EN
    logic [31:0] grants_q [N_REQ];
    logic [31:0] busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int i = 0; i < N_REQ; i++) grants_q[i] <= '0;
        end else begin
            if (mm_valid_q && (busy_q != '1)) busy_q <= busy_q + 32'd1;
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt[i] && (grants_q[i] != '1)) grants_q[i] <= grants_q[i] + 32'd1;
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < N_REQ; i++) stat_grants[i*32 +: 32] = grants_q[i];
    end
    assign stat_busy = busy_q;
`endif

endmodule
